pipe_retire_monitor: RTL
========================

Name: pipe_retire_monitor

Overview:
Parametrised writeback-stage retirement monitor and run controller for the Y86 pipeline. It replaces simulation-only `$finish` status handling with synthesizable logic. It watches the W stage, F_st, D_bub and E_bub; counts cycles, retirements, stalls and bubbles; keeps a circular history of retired PCs; and drives a sticky RUN/HALTED/FAULT state machine. Its `run` output freezes the pipeline and it is instantiated beside p_control in pipe.

Parameters:
CNT_W, 32, width of every performance counter
HIST_DEPTH, 8, retired-PC history entries; power of 2, minimum 2
HIST_AW, 3, log2(HIST_DEPTH); index width
PC_W, 64, PC width

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
W_stat  input  2  W-stage status: 0 AOK, 1 HLT, 2 ADR, 3 INS
W_in_code  input  4  W-stage icode; 4'h1 (nop/bubble) never counts as retired
W_pc  input  PC_W  PC of the W-stage instruction
F_st  input  1  fetch stall this cycle
D_bub  input  1  decode bubble this cycle
E_bub  input  1  execute bubble this cycle
clear  input  1  synchronous clear of counters and history
restart  input  1  synchronous return from HALTED/FAULT to RUN
run  output  1  1 in RUN; pipe gates clock-enable with it
halted  output  1  1 in HALTED
fault  output  1  1 in FAULT
final_stat  output  2  W_stat captured on leaving RUN
fault_pc  output  PC_W  W_pc captured on entering FAULT
cycle_cnt  output  CNT_W  cycles spent in RUN
retire_cnt  output  CNT_W  retired instructions
stall_cnt  output  CNT_W  RUN cycles with F_st=1
bubble_cnt  output  CNT_W  bubbles inserted (D_bub + E_bub)
hist_rd_idx  input  HIST_AW  0 = most recent retirement
hist_rd_pc  output  PC_W  history entry at hist_rd_idx
hist_count  output  HIST_AW+1  valid history entries

Behaviour:
- Reset (reset_n=0, asynchronous): state RUN, so run=1 and halted=fault=0; final_stat=0, fault_pc=0, all counters 0, history empty (hist_count=0, write pointer 0).
- All outputs are registered except hist_rd_pc, which is a combinational read of the history registers.
- FSM states: RUN, HALTED, FAULT. Both HALTED and FAULT are sticky.
- RUN, W_stat=AOK: stay in RUN.
- RUN, W_stat=HLT: go to HALTED. final_stat=1. The halt counts as a retirement and its W_pc is pushed into history.
- RUN, W_stat=ADR or INS: go to FAULT. final_stat=W_stat and fault_pc=W_pc. Not counted as retired; nothing pushed.
- HALTED/FAULT, restart=1: go to RUN next edge. final_stat and fault_pc are held. W inputs are ignored on the restart cycle itself.
- HALTED/FAULT, restart=0: W inputs, F_st and bubbles are ignored; counters are frozen.
- restart while in RUN has no effect.
- Retirement (RUN only): W_stat in {AOK, HLT} and W_in_code != 4'h1. Each retirement increments retire_cnt by 1 and pushes W_pc.
- cycle_cnt: +1 every edge spent in RUN, including the edge that leaves RUN.
- stall_cnt: +1 when F_st=1 in RUN.
- bubble_cnt: + (D_bub + E_bub) in RUN, i.e. 0, 1 or 2 per cycle.
- All counters saturate at 2^CNT_W-1. No wrap; a +2 step from max-1 clamps to max.
- History is a circular buffer:
  - A push writes at wr_ptr and wr_ptr increments modulo HIST_DEPTH, overwriting the oldest entry when full.
  - hist_count increments and saturates at HIST_DEPTH.
  - Read address is (wr_ptr-1-hist_rd_idx) mod HIST_DEPTH.
  - hist_rd_idx >= hist_count returns 0.
- clear=1: all four counters and the history (count and pointer) go to 0 next edge. clear beats any same-cycle increment or push, so the event is dropped. clear does not change FSM state, final_stat or fault_pc.
- clear together with restart: both take effect.
- Reset mid-operation: immediate asynchronous return to the reset values, regardless of state.

Test Plan:
- Reset, then 10 cycles of AOK with W_in_code=4'h6 and W_pc=0,2,...,18 -> cycle_cnt=10, retire_cnt=10, hist_count=8; hist_rd_idx=0 gives 18, idx 7 gives 4.
- 5 RUN cycles with W_in_code=4'h1 and D_bub=E_bub=1, F_st=1 on 3 of them -> retire_cnt unchanged, bubble_cnt +10, stall_cnt +3.
- W_stat=1 with W_pc=0x40 -> next edge halted=1, run=0, final_stat=1, retire_cnt+1, idx0=0x40. Then 5 more cycles with traffic -> no counter changes. Then restart -> run=1.
- W_stat=3 with W_pc=0x1C -> fault=1, fault_pc=0x1C, final_stat=3, retire_cnt unchanged, no history push.
- CNT_W=4: retire_cnt preloaded to 15 by retirements -> stays 15. bubble_cnt at 14 with D_bub=E_bub=1 -> 15.
- clear asserted in the same cycle as a retirement -> all counters 0, hist_count=0, FSM still RUN. Then reset_n pulsed low mid-cycle while in FAULT -> outputs return to reset values immediately, before any clock edge.

Source files
------------

// File: rtl/pipe_retire_monitor.sv
// Writeback-stage retirement monitor and run controller for the Y86 pipeline.
// Counts activity, records retired PCs and latches a sticky RUN/HALTED/FAULT state.
module pipe_retire_monitor #(
  parameter int CNT_W      = 32,
  parameter int HIST_DEPTH = 8,
  parameter int HIST_AW    = 3,
  parameter int PC_W       = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         W_stat,
  input  logic [3:0]         W_in_code,
  input  logic [PC_W-1:0]    W_pc,
  input  logic               F_st,
  input  logic               D_bub,
  input  logic               E_bub,
  input  logic               clear,
  input  logic               restart,
  output logic               run,
  output logic               halted,
  output logic               fault,
  output logic [1:0]         final_stat,
  output logic [PC_W-1:0]    fault_pc,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  input  logic [HIST_AW-1:0] hist_rd_idx,
  output logic [PC_W-1:0]    hist_rd_pc,
  output logic [HIST_AW:0]   hist_count
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;

  localparam logic [HIST_AW:0] DEPTH_FULL = (HIST_AW+1)'(HIST_DEPTH);

  logic [1:0]         state_q, state_d;
  logic [1:0]         finalStat_q, finalStat_d;
  logic [PC_W-1:0]    faultPc_q, faultPc_d;
  logic [CNT_W-1:0]   cycleCnt_q, cycleCnt_d;
  logic [CNT_W-1:0]   retireCnt_q, retireCnt_d;
  logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]   bubbleCnt_q, bubbleCnt_d;
  logic [HIST_AW-1:0] wrPtr_q, wrPtr_d;
  logic [HIST_AW:0]   histCount_q, histCount_d;
  logic [PC_W-1:0]    hist_q [HIST_DEPTH];

  logic               inRun;
  logic               retire;
  logic               push;
  logic [1:0]         bubbleInc;
  logic [HIST_AW-1:0] rdAddr;

  // Saturating add; a +2 step from max-1 clamps at max.
  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] c,
                                              input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, c} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign inRun     = (state_q == ST_RUN);
  assign retire    = inRun && ((W_stat == STAT_AOK) || (W_stat == STAT_HLT)) && (W_in_code != 4'h1);
  assign push      = retire && !clear;
  assign bubbleInc = {1'b0, D_bub} + {1'b0, E_bub};

  always_comb begin
    state_d     = state_q;
    finalStat_d = finalStat_q;
    faultPc_d   = faultPc_q;
    case (state_q)
      ST_RUN: begin
        if (W_stat == STAT_HLT) begin
          state_d     = ST_HALTED;
          finalStat_d = W_stat;
        end else if (W_stat != STAT_AOK) begin
          state_d     = ST_FAULT;
          finalStat_d = W_stat;
          faultPc_d   = W_pc;
        end
      end
      ST_HALTED, ST_FAULT: begin
        if (restart) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Counters only move while running; clear wins over any same-cycle event.
  always_comb begin
    cycleCnt_d  = cycleCnt_q;
    retireCnt_d = retireCnt_q;
    stallCnt_d  = stallCnt_q;
    bubbleCnt_d = bubbleCnt_q;
    wrPtr_d     = wrPtr_q;
    histCount_d = histCount_q;
    if (clear) begin
      cycleCnt_d  = '0;
      retireCnt_d = '0;
      stallCnt_d  = '0;
      bubbleCnt_d = '0;
      wrPtr_d     = '0;
      histCount_d = '0;
    end else if (inRun) begin
      cycleCnt_d  = satAdd(cycleCnt_q, 2'd1);
      bubbleCnt_d = satAdd(bubbleCnt_q, bubbleInc);
      if (F_st) stallCnt_d = satAdd(stallCnt_q, 2'd1);
      if (retire) begin
        retireCnt_d = satAdd(retireCnt_q, 2'd1);
        wrPtr_d     = wrPtr_q + HIST_AW'(1);
        if (histCount_q != DEPTH_FULL) histCount_d = histCount_q + (HIST_AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      finalStat_q <= '0;
      faultPc_q   <= '0;
      cycleCnt_q  <= '0;
      retireCnt_q <= '0;
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
      wrPtr_q     <= '0;
      histCount_q <= '0;
    end else begin
      state_q     <= state_d;
      finalStat_q <= finalStat_d;
      faultPc_q   <= faultPc_d;
      cycleCnt_q  <= cycleCnt_d;
      retireCnt_q <= retireCnt_d;
      stallCnt_q  <= stallCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
      wrPtr_q     <= wrPtr_d;
      histCount_q <= histCount_d;
    end
  end

  // History payload needs no reset: entries beyond hist_count are never read out.
  always_ff @(posedge clock) begin
    if (push) hist_q[wrPtr_q] <= W_pc;
  end

  assign rdAddr     = wrPtr_q - HIST_AW'(1) - hist_rd_idx;
  assign hist_rd_pc = ({1'b0, hist_rd_idx} < histCount_q) ? hist_q[rdAddr] : '0;

  assign run        = (state_q == ST_RUN);
  assign halted     = (state_q == ST_HALTED);
  assign fault      = (state_q == ST_FAULT);
  assign final_stat = finalStat_q;
  assign fault_pc   = faultPc_q;
  assign cycle_cnt  = cycleCnt_q;
  assign retire_cnt = retireCnt_q;
  assign stall_cnt  = stallCnt_q;
  assign bubble_cnt = bubbleCnt_q;
  assign hist_count = histCount_q;

endmodule
